// File: rtl/pin_phys_pkg.sv
// Shared pin physics types and constants for the collision and integrator blocks.
// Positions are 17-bit signed fixed point with FRAC_BITS fraction bits.
package pin_phys_pkg;
  localparam int NUM_PINS       = 10;
  localparam int FRAC_BITS      = 4;
  localparam int FRICTION_SHIFT = 3;
  localparam int STOP_THRESH    = 8;
  localparam int SCREEN_WIDTH   = 1024;
  localparam int SCREEN_HEIGHT  = 768;

  localparam logic signed [16:0] X_LIM_FX = 17'(SCREEN_WIDTH  * (1 << FRAC_BITS));
  localparam logic signed [16:0] Y_LIM_FX = 17'(SCREEN_HEIGHT * (1 << FRAC_BITS));

  // Standard triangle rack, head pin first, rows widening toward the back.
  localparam logic [10:0] RACK_X [NUM_PINS] = '{
    11'd512, 11'd496, 11'd528, 11'd480, 11'd512,
    11'd544, 11'd464, 11'd496, 11'd528, 11'd560};
  localparam logic [9:0]  RACK_Y [NUM_PINS] = '{
    10'd100, 10'd128, 10'd128, 10'd156, 10'd156,
    10'd156, 10'd184, 10'd184, 10'd184, 10'd184};

  typedef struct packed {
    logic signed [16:0] pos_x_fx;
    logic signed [16:0] pos_y_fx;
    logic signed [15:0] vx;
    logic signed [15:0] vy;
    logic               down;
  } pin_state_t;

  typedef enum logic [1:0] {ST_IDLE, ST_UPDATE, ST_DONE} integ_state_t;

  function automatic pin_state_t rack_state(input int i);
    pin_state_t s;
    s.pos_x_fx = {2'b00, RACK_X[i], 4'b0000};
    s.pos_y_fx = {3'b000, RACK_Y[i], 4'b0000};
    s.vx       = '0;
    s.vy       = '0;
    s.down     = 1'b0;
    return s;
  endfunction

  function automatic logic signed [15:0] apply_friction(input logic signed [15:0] v);
    logic signed [15:0] vt;
    logic signed [15:0] mag;
    vt  = v - (v >>> FRICTION_SHIFT);
    mag = vt[15] ? -vt : vt;
    return (mag < 16'sd8) ? 16'sd0 : vt;
  endfunction
endpackage

// File: rtl/pin_step.sv
// One-pin kinematic step: integrate, bounds check against the lane, friction.
// Purely combinational; the integrator time-multiplexes it across pins.
module pin_step
  import pin_phys_pkg::*;
(
  input  pin_state_t         cur_in,
  input  logic               hit_in,
  input  logic signed [15:0] snap_vx_in,
  input  logic signed [15:0] snap_vy_in,
  output pin_state_t         nxt_out,
  output logic               fell_out
);
  logic signed [15:0] vx, vy;
  logic signed [16:0] nx, ny;
  logic               out_of_lane;

  always_comb begin
    vx = hit_in ? snap_vx_in : cur_in.vx;
    vy = hit_in ? snap_vy_in : cur_in.vy;
    // 17-bit sums: an in-lane position plus any 16-bit velocity cannot wrap
    nx = cur_in.pos_x_fx + 17'(vx);
    ny = cur_in.pos_y_fx + 17'(vy);
    out_of_lane = (nx < 17'sd0) || (nx >= X_LIM_FX) ||
                  (ny < 17'sd0) || (ny >= Y_LIM_FX);

    nxt_out  = cur_in;
    fell_out = 1'b0;
    if (!cur_in.down) begin
      if (out_of_lane) begin
        nxt_out.pos_x_fx = X_LIM_FX;
        nxt_out.pos_y_fx = Y_LIM_FX;
        nxt_out.vx       = '0;
        nxt_out.vy       = '0;
        nxt_out.down     = 1'b1;
        fell_out         = 1'b1;
      end else begin
        nxt_out.pos_x_fx = nx;
        nxt_out.pos_y_fx = ny;
        nxt_out.vx       = apply_friction(vx);
        nxt_out.vy       = apply_friction(vy);
      end
    end
  end
endmodule

// File: rtl/pin_integrator.sv
// Per-frame pin integrator: snapshots collision velocities on valid_in, then
// steps one pin per cycle through a shared pin_step and pulses done.
module pin_integrator
  import pin_phys_pkg::*;
(
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            init_in,
  input  logic                            valid_in,
  input  logic [NUM_PINS-1:0][15:0]       pins_vx_in,
  input  logic [NUM_PINS-1:0][15:0]       pins_vy_in,
  input  logic [NUM_PINS-1:0]             pins_hit_in,
  output logic [NUM_PINS-1:0][10:0]       pins_x,
  output logic [NUM_PINS-1:0][9:0]        pins_y,
  output logic [NUM_PINS-1:0][15:0]       pins_vx_out,
  output logic [NUM_PINS-1:0][15:0]       pins_vy_out,
  output logic [NUM_PINS-1:0]             pins_down,
  output logic [3:0]                      pins_down_count,
  output logic                            busy,
  output logic                            done
);
  integ_state_t               state_q, state_d;
  logic [3:0]                 idx_q, idx_d;
  pin_state_t                 pins_q [NUM_PINS];
  pin_state_t                 pins_d [NUM_PINS];
  logic [NUM_PINS-1:0][15:0]  snap_vx_q, snap_vx_d;
  logic [NUM_PINS-1:0][15:0]  snap_vy_q, snap_vy_d;
  logic [NUM_PINS-1:0]        hit_q, hit_d;
  logic [3:0]                 count_q, count_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  pin_state_t         cur_pin, nxt_pin;
  logic               cur_hit, fell;
  logic signed [15:0] cur_svx, cur_svy;

  always_comb begin
    cur_pin = pins_q[0];
    cur_hit = hit_q[0];
    cur_svx = snap_vx_q[0];
    cur_svy = snap_vy_q[0];
    for (int i = 1; i < NUM_PINS; i++) begin
      if (idx_q == 4'(i)) begin
        cur_pin = pins_q[i];
        cur_hit = hit_q[i];
        cur_svx = snap_vx_q[i];
        cur_svy = snap_vy_q[i];
      end
    end
  end

  pin_step u_step (
    .cur_in     (cur_pin),
    .hit_in     (cur_hit),
    .snap_vx_in (cur_svx),
    .snap_vy_in (cur_svy),
    .nxt_out    (nxt_pin),
    .fell_out   (fell)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pins_d    = pins_q;
    snap_vx_d = snap_vx_q;
    snap_vy_d = snap_vy_q;
    hit_d     = hit_q;
    count_d   = count_q;
    case (state_q)
      ST_IDLE: begin
        if (init_in) begin
          for (int i = 0; i < NUM_PINS; i++) pins_d[i] = rack_state(i);
          count_d = '0;
        end else if (valid_in) begin
          snap_vx_d = pins_vx_in;
          snap_vy_d = pins_vy_in;
          hit_d     = pins_hit_in;
          idx_d     = '0;
          state_d   = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        for (int i = 0; i < NUM_PINS; i++)
          if (idx_q == 4'(i)) pins_d[i] = nxt_pin;
        if (fell) count_d = count_q + 4'd1;
        if (idx_q == 4'(NUM_PINS - 1)) state_d = ST_DONE;
        else                           idx_d   = idx_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      for (int i = 0; i < NUM_PINS; i++) pins_q[i] <= rack_state(i);
      snap_vx_q <= '0;
      snap_vy_q <= '0;
      hit_q     <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pins_q    <= pins_d;
      snap_vx_q <= snap_vx_d;
      snap_vy_q <= snap_vy_d;
      hit_q     <= hit_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PINS; i++) begin
      pins_x[i]      = pins_q[i].pos_x_fx[FRAC_BITS +: 11];
      pins_y[i]      = pins_q[i].pos_y_fx[FRAC_BITS +: 10];
      pins_vx_out[i] = pins_q[i].vx;
      pins_vy_out[i] = pins_q[i].vy;
      pins_down[i]   = pins_q[i].down;
    end
  end

  assign pins_down_count = count_q;
  assign busy            = busy_q;
  assign done            = done_q;
endmodule
